cache_mem_bridge: RTL and testbench

CACHE_MEM_BRIDGE -- requirements
Module: cache_mem_bridge

---
 rtl/cache_mem_bridge.sv | 172 +++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_bridge.sv
// Cache-to-bus bridge.
// A line read issues one line-aligned address beat and then collects BEATS
// response beats into a line buffer. A word write issues an address beat
// followed by a data beat. Each transaction ends with a one-cycle completion
// pulse. Only one transaction is in flight at a time.
module cache_mem_bridge #(
    parameter int WIDTH       = 64,
    parameter int BLOCKSZ     = 512,
    parameter int ADDRESSSIZE = 64,
    parameter int TAGWIDTH    = 13,
    parameter logic [TAGWIDTH-1:0] READ_TAG  = TAGWIDTH'(13'h1100),
    parameter logic [TAGWIDTH-1:0] WRITE_TAG = TAGWIDTH'(13'h0100)
) (
    input  logic                   clk,
    input  logic                   rst,
    // cache side
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDRESSSIZE-1:0] mem_address,
    input  logic                   mem_wr_en,
    input  logic [WIDTH-1:0]       mem_data_out,
    output logic [BLOCKSZ-1:0]     mem_data_in,
    output logic                   mem_data_valid,
    // bus request channel
    output logic                   bus_reqcyc,
    input  logic                   bus_reqack,
    output logic [WIDTH-1:0]       bus_req,
    output logic [TAGWIDTH-1:0]    bus_reqtag,
    // bus response channel
    input  logic                   bus_respcyc,
    output logic                   bus_respack,
    input  logic [WIDTH-1:0]       bus_resp
);

    localparam int BEATS = BLOCKSZ / WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Byte-offset bits inside one cache line; cleared for line reads.
    localparam int OFF_W = $clog2(BLOCKSZ / 8);
    localparam logic [ADDRESSSIZE-1:0] ALIGN_MASK = {ADDRESSSIZE{1'b1}} << OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESSSIZE-1:0]   addr_hold;
    logic [WIDTH-1:0]         wdata_hold;
    logic [CNT_W-1:0]         beat_cnt;
    logic [BLOCKSZ-1:0]       line_buf;
    logic [BLOCKSZ-1:0]       line_next;
    logic                     accept;
    logic                     beat_take;
    logic                     last_beat;

    assign accept    = (state == IDLE) && req_valid;
    assign beat_take = (state == RD_DATA) && bus_respcyc;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    // State register; reset returns to IDLE from anywhere, mid-burst included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and all bus/cache handshake outputs.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        mem_data_valid = 1'b0;
        bus_reqcyc     = 1'b0;
        bus_req        = '0;
        bus_reqtag     = '0;
        bus_respack    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = mem_wr_en ? WR_ADDR : RD_REQ;
                end
            end
            RD_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = WIDTH'(addr_hold & ALIGN_MASK);
                bus_reqtag = READ_TAG;
                if (bus_reqack) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                // Every offered beat is taken immediately; gaps simply stall.
                bus_respack = bus_respcyc;
                if (bus_respcyc && last_beat) begin
                    state_next = DONE;
                end
            end
            WR_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = WIDTH'(addr_hold);
                bus_reqtag = WRITE_TAG;
                if (bus_reqack) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = wdata_hold;
                bus_reqtag = WRITE_TAG;
                if (bus_reqack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                mem_data_valid = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request so the bus beats stay stable while the cache moves on.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            addr_hold  <= mem_address;
            wdata_hold <= mem_data_out;
        end
    end

    // Beat counter: cleared when the read address is taken, wraps after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if ((state == RD_REQ) && bus_reqack) begin
            beat_cnt <= '0;
        end else if (beat_take) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // Line buffer with the incoming beat dropped into its slot.
    always_comb begin
        line_next = line_buf;
        line_next[beat_cnt*WIDTH +: WIDTH] = bus_resp;
    end

    // Partial line accumulation; every slot is rewritten by each read.
    always_ff @(posedge clk) begin
        if (!rst && beat_take) begin
            line_buf <= line_next;
        end
    end

    // Cache-visible line only changes when a whole read has completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data_in <= '0;
        end else if (beat_take && last_beat) begin
            mem_data_in <= line_next;
        end
    end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Bench for cache_mem_bridge: directed scenarios followed by randomized
// read/write traffic with random bus delays, gaps, stray beats and aborts,
// checked against a transaction-level model of the bridge.
module tb_cache_mem_bridge;

    localparam int WIDTH       = 64;
    localparam int BLOCKSZ     = 512;
    localparam int ADDRESSSIZE = 64;
    localparam int TAGWIDTH    = 13;
    localparam int BEATS       = BLOCKSZ / WIDTH;
    localparam logic [TAGWIDTH-1:0] READ_TAG  = 13'h1100;
    localparam logic [TAGWIDTH-1:0] WRITE_TAG = 13'h0100;

    logic                   clk;
    logic                   rst;
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDRESSSIZE-1:0] mem_address;
    logic                   mem_wr_en;
    logic [WIDTH-1:0]       mem_data_out;
    logic [BLOCKSZ-1:0]     mem_data_in;
    logic                   mem_data_valid;
    logic                   bus_reqcyc;
    logic                   bus_reqack;
    logic [WIDTH-1:0]       bus_req;
    logic [TAGWIDTH-1:0]    bus_reqtag;
    logic                   bus_respcyc;
    logic                   bus_respack;
    logic [WIDTH-1:0]       bus_resp;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Model state: the line the cache should currently see.
    logic [BLOCKSZ-1:0] model_line;
    logic [WIDTH-1:0]   beat_data [BEATS];

    cache_mem_bridge #(
        .WIDTH(WIDTH), .BLOCKSZ(BLOCKSZ), .ADDRESSSIZE(ADDRESSSIZE),
        .TAGWIDTH(TAGWIDTH), .READ_TAG(READ_TAG), .WRITE_TAG(WRITE_TAG)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_data_valid(mem_data_valid),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic fill_beats();
        for (int i = 0; i < BEATS; i++) beat_data[i] = {$urandom, $urandom};
    endtask

    // One line read. gap_mode: 0 back-to-back, 1 alternating, 2 random gaps.
    // abort_at > 0 asserts reset once that many beats have been taken.
    task automatic run_read(input logic [63:0] addr, input int ack_dly, input int gap_mode,
                            input bit hold_valid, input int abort_at);
        logic [BLOCKSZ-1:0] exp_line;
        logic [63:0]        exp_addr;
        int                 k;
        int                 cyc;
        bit                 rc;
        exp_line = '0;
        for (int i = BEATS - 1; i >= 0; i--) exp_line = (exp_line << WIDTH) | BLOCKSZ'(beat_data[i]);
        exp_addr = addr & ~64'h3F;

        req_valid = 1'b1; mem_address = addr; mem_wr_en = 1'b0; mem_data_out = {$urandom, $urandom};
        #1;
        check_eq("rd_ready", 512'(req_ready), 512'(1));
        @(posedge clk); #1;
        if (hold_valid) begin
            mem_address = addr ^ 64'h0000_5555_0000_0000;
            mem_wr_en   = 1'b1;
        end else begin
            req_valid = 1'b0;
        end

        for (int c = 0; c <= ack_dly; c++) begin
            bus_reqack = (c == ack_dly);
            #1;
            check_eq("rd_reqcyc", 512'(bus_reqcyc), 512'(1));
            check_eq("rd_addr", 512'(bus_req), 512'(exp_addr));
            check_eq("rd_tag", 512'(bus_reqtag), 512'(READ_TAG));
            check_eq("rd_busy", 512'(req_ready), 512'(0));
            @(posedge clk); #1;
        end
        bus_reqack = 1'b0;

        k = 0; cyc = 0;
        while (k < BEATS && cyc < 200) begin
            case (gap_mode)
                0:       rc = 1'b1;
                1:       rc = (cyc % 2 == 0);
                default: rc = ($urandom_range(0, 2) != 0);
            endcase
            bus_respcyc = rc;
            bus_resp    = rc ? beat_data[k] : {$urandom, $urandom};
            #1;
            check_eq("rd_respack", 512'(bus_respack), 512'(rc));
            check_eq("rd_early_valid", 512'(mem_data_valid), 512'(0));
            check_eq("rd_busy_data", 512'(req_ready), 512'(0));
            @(posedge clk); #1;
            cyc++;
            if (rc) k++;
            if (abort_at > 0 && k == abort_at) break;
        end
        bus_respcyc = 1'b0;

        if (abort_at > 0 && k == abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            req_valid = 1'b0;
            check_eq("abort_ready", 512'(req_ready), 512'(1));
            check_eq("abort_valid", 512'(mem_data_valid), 512'(0));
            check_eq("abort_line", 512'(mem_data_in), 512'(0));
            check_eq("abort_reqcyc", 512'(bus_reqcyc), 512'(0));
            model_line = '0;
            return;
        end
        if (k < BEATS) begin
            check_eq("rd_timeout", 512'(k), 512'(BEATS));
            return;
        end
        if (gap_mode == 1) check_eq("rd_toggle_cycles", 512'(cyc), 512'(2 * BEATS - 1));

        check_eq("rd_valid", 512'(mem_data_valid), 512'(1));
        check_eq("rd_line", 512'(mem_data_in), 512'(exp_line));
        check_eq("rd_done_busy", 512'(req_ready), 512'(0));
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rd_pulse_end", 512'(mem_data_valid), 512'(0));
        check_eq("rd_idle_ready", 512'(req_ready), 512'(1));
        check_eq("rd_line_hold", 512'(mem_data_in), 512'(exp_line));
        model_line = exp_line;
    endtask

    // One word write with independent address/data acknowledge delays.
    task automatic run_write(input logic [63:0] addr, input logic [63:0] data,
                             input int dly_a, input int dly_d);
        req_valid = 1'b1; mem_address = addr; mem_wr_en = 1'b1; mem_data_out = data;
        #1;
        check_eq("wr_ready", 512'(req_ready), 512'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_data_out = ~data;
        for (int c = 0; c <= dly_a; c++) begin
            bus_reqack  = (c == dly_a);
            bus_respcyc = ($urandom_range(0, 3) == 0);
            bus_resp    = {$urandom, $urandom};
            #1;
            check_eq("wr_addr_cyc", 512'(bus_reqcyc), 512'(1));
            check_eq("wr_addr", 512'(bus_req), 512'(addr));
            check_eq("wr_addr_tag", 512'(bus_reqtag), 512'(WRITE_TAG));
            check_eq("wr_stray_ack", 512'(bus_respack), 512'(0));
            @(posedge clk); #1;
        end
        for (int c = 0; c <= dly_d; c++) begin
            bus_reqack  = (c == dly_d);
            bus_respcyc = ($urandom_range(0, 3) == 0);
            bus_resp    = {$urandom, $urandom};
            #1;
            check_eq("wr_data_cyc", 512'(bus_reqcyc), 512'(1));
            check_eq("wr_data", 512'(bus_req), 512'(data));
            check_eq("wr_data_tag", 512'(bus_reqtag), 512'(WRITE_TAG));
            @(posedge clk); #1;
        end
        bus_reqack = 1'b0; bus_respcyc = 1'b0;
        check_eq("wr_valid", 512'(mem_data_valid), 512'(1));
        check_eq("wr_line_kept", 512'(mem_data_in), 512'(model_line));
        check_eq("wr_done_reqcyc", 512'(bus_reqcyc), 512'(0));
        @(posedge clk); #1;
        check_eq("wr_pulse_end", 512'(mem_data_valid), 512'(0));
        check_eq("wr_idle_ready", 512'(req_ready), 512'(1));
    endtask

    // A response beat offered while idle must be ignored.
    task automatic stray_beat();
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        #1;
        check_eq("stray_ack", 512'(bus_respack), 512'(0));
        @(posedge clk); #1;
        bus_respcyc = 1'b0;
        check_eq("stray_line", 512'(mem_data_in), 512'(model_line));
        check_eq("stray_ready", 512'(req_ready), 512'(1));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b1; mem_address = 64'h1234_5678; mem_wr_en = 1'b0;
        mem_data_out = '0; bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
        model_line = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check_eq("rst_ready", 512'(req_ready), 512'(1));
        check_eq("rst_valid", 512'(mem_data_valid), 512'(0));
        check_eq("rst_line", 512'(mem_data_in), 512'(0));
        check_eq("rst_reqcyc", 512'(bus_reqcyc), 512'(0));
        check_eq("rst_req", 512'(bus_req), 512'(0));
        check_eq("rst_tag", 512'(bus_reqtag), 512'(0));
        check_eq("rst_respack", 512'(bus_respack), 512'(0));
        @(posedge clk); #1;
        check_eq("rst_no_accept", 512'(bus_reqcyc), 512'(0));

        // Directed line read: ack after 2 cycles, beats 0x11..0x88.
        for (int i = 0; i < BEATS; i++) beat_data[i] = 64'(8'h11 * (i + 1));
        run_read(64'h1000_0047, 2, 0, 1'b0, 0);
        check_eq("dir_low_beat", 512'(mem_data_in[63:0]), 512'(64'h11));
        check_eq("dir_high_beat", 512'(mem_data_in[511:448]), 512'(64'h88));

        // Directed word write with immediate acks.
        run_write(64'h2008, 64'hDEAD_BEEF, 0, 0);

        // Alternating response gaps.
        fill_beats();
        run_read(64'h0000_ABCD_0123_4567, 0, 1, 1'b0, 0);

        // Stray idle beat, then a read with req_valid held high throughout.
        stray_beat();
        fill_beats();
        run_read(64'h0000_0000_8000_00FF, 1, 2, 1'b1, 0);

        // Reset after beat 3, then a fresh read.
        fill_beats();
        run_read(64'h0000_0000_3000_0000, 0, 0, 1'b0, 4);
        fill_beats();
        run_read(64'h0000_0000_3000_0040, 0, 0, 1'b0, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) stray_beat();
            if ($urandom_range(0, 2) == 0) begin
                run_write({$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                fill_beats();
                run_read({$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 2),
                         ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 7) == 0) ? $urandom_range(1, BEATS - 1) : 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
